dsd9_bus_decoder: RTL and testbench
===================================

# dsd9_bus_decoder

Parametrised system-bus decoder/interconnect between the DSD9 MPU bus master and NS slave ports. It replaces the ad-hoc wired-OR of slave acks and data with a registered, address-decoded steering path. It adds a bus-error response for unmapped addresses and for slaves that never acknowledge, plus a fault-capture register for the error handler. It sits between `DSD9_mpu` and the bootrom, scratch RAM, main memory and IOBridge slaves.

## Interface
Parameters:
- `NS`, 8, number of slave ports (1..16)
- `AW`, 32, address width
- `DW`, 128, data width; `sel` width is DW/8
- `SLV_BASE`, 0, packed NS*AW; base address of slave i in bits [i*AW +: AW]
- `SLV_MASK`, 0, packed NS*AW; slave i matches when (adr & mask_i) == (base_i & mask_i); an all-zero mask disables the port
- `TIMEOUT`, 255, cycles in ACTIVE before a timeout error (>=1)

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1 system clock
- `rst_i` in 1 asynchronous active-high reset
- `m_cyc_i`, `m_stb_i`, `m_wr_i` in 1 master cycle, strobe, write
- `m_sel_i` in DW/8 byte selects
- `m_adr_i` in AW address
- `m_dat_i` in DW write data
- `m_ack_o` out 1 acknowledge
- `m_err_o` out 1 bus error
- `m_dat_o` out DW read data
- `s_cyc_o`, `s_stb_o` out NS per-slave cycle/strobe (one-hot or zero)
- `s_ack_i` in NS per-slave ack
- `s_dat_i` in NS*DW per-slave read data
- `s_wr_o` out 1; `s_sel_o` out DW/8; `s_adr_o` out AW; `s_dat_o` out DW; registered copies of master request
- `clr_fault_i` in 1 clears fault register
- `fault_valid_o` out 1; `fault_cause_o` out 1 (0 = no decode, 1 = timeout); `fault_adr_o` out AW

## Operation
- States: IDLE, ACTIVE, ACK, ERR.
- IDLE: on `m_cyc_i & m_stb_i`, evaluate matcher. Hit -> latch slave index, adr/sel/wr/dat into `s_*` registers, assert `s_cyc_o[idx]`/`s_stb_o[idx]`, clear timer, go ACTIVE. Miss -> go ERR, capture fault (cause 0).
- Overlapping regions: lowest index wins.
- ACTIVE: timer increments each cycle. `s_ack_i[idx]` -> latch `s_dat_i[idx]` into `m_dat_o`, drop slave cyc/stb, go ACK. Acks from non-selected ports ignored. Timer == TIMEOUT without ack -> drop slave strobes, go ERR, capture fault (cause 1). Ack and expiry in the same cycle: ack wins.
- `m_cyc_i` low in ACTIVE (abort): drop slave strobes, go IDLE; no ack or err.
- ACK: `m_ack_o`=1 while `m_stb_i` high; `m_stb_i` low -> IDLE.
- ERR: `m_err_o`=1 while `m_stb_i` high; `m_stb_i` low -> IDLE.
- Fault register: set (valid, cause, adr) on entry to ERR; cleared by `clr_fault_i`. Set and clear in the same cycle: set wins. A second fault overwrites the first.
- `m_dat_o` holds the last read data; it is unchanged on error and on writes.

## Timing
- Reset: state IDLE, all `s_cyc_o`/`s_stb_o`/`m_ack_o`/`m_err_o`/`fault_valid_o` = 0, `fault_cause_o` = 0, all address/data outputs = 0, timer = 0.
- Request at edge N -> slave strobe visible after edge N+1.
- Slave ack sampled at edge K -> `m_ack_o` high after edge K. Minimum read latency: 2 cycles plus slave latency.
- Miss: `m_err_o` high after the first edge following the request.
- Timeout: `m_err_o` high TIMEOUT+1 cycles after slave strobe assertion.
- Back-to-back: a new request is accepted only from IDLE, so there is 1 dead cycle after the master drops stb.
- Timer width: $clog2(TIMEOUT+1); saturating, never wraps.
- Reset mid-transaction: all outputs return to reset values asynchronously.

## Structure
- Package `dsd9_bus_pkg`: state enum (IDLE/ACTIVE/ACK/ERR), fault cause constants `FC_NODECODE`=0 and `FC_TIMEOUT`=1.
- Sub-module `dsd9_bus_addr_match`: combinational priority matcher (adr, bases, masks -> hit, index).

## Test plan
Test configuration: NS=4, base0=FFFC0000 mask FFFC0000, base1=00000000 mask F0000000, base2=FFD00000 mask FFF00000, TIMEOUT=8.
- Read FFFC0010, slave 0 acks 1 cycle after strobe with data 0xA5.. -> `s_stb_o`=0001, `m_ack_o` high 2 cycles after strobe, `m_dat_o`=0xA5..
- Write 00001000, sel=FFFF -> `s_stb_o`=0010; `s_wr_o`/`s_sel_o`/`s_dat_o` match the master; `m_dat_o` unchanged.
- Access 80000000 (unmapped) -> `m_err_o`=1 next cycle; fault_valid=1, cause=0, adr=80000000; no slave strobe.
- Access FFD00000, slave 2 silent -> `m_err_o` after 9 cycles; cause=1; `clr_fault_i` pulse -> valid=0.
- Slave 3 acks spuriously during a slave-1 access -> ignored; ack arrives on the expiry cycle -> `m_ack_o`, not `m_err_o`.
- `m_cyc_i` dropped in ACTIVE, then reset asserted mid-access -> strobes cleared; all outputs at reset values.

Source files
------------

// File: rtl/dsd9_bus_pkg.sv
// Shared types for the DSD9 system-bus decoder: transaction states and fault cause codes.
package dsd9_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ACK    = 2'd2,
        ST_ERR    = 2'd3
    } bus_state_e;

    localparam logic FC_NODECODE = 1'b0;
    localparam logic FC_TIMEOUT  = 1'b1;

endpackage

// File: rtl/dsd9_bus_addr_match.sv
// Combinational priority address matcher; the lowest-numbered enabled port that matches wins.
module dsd9_bus_addr_match #(
    parameter int NS = 8,
    parameter int AW = 32,
    parameter int IW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic [AW-1:0]    adr_i,
    input  logic [NS*AW-1:0] base_i,
    input  logic [NS*AW-1:0] mask_i,
    output logic             hit_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        // Scan downwards so a lower index overwrites any higher match.
        for (int i = NS - 1; i >= 0; i--) begin
            if ((mask_i[i*AW +: AW] != '0) &&
                ((adr_i & mask_i[i*AW +: AW]) == (base_i[i*AW +: AW] & mask_i[i*AW +: AW]))) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dsd9_bus_decoder.sv
// DSD9 system-bus decoder: registered, address-decoded steering from one master to NS slaves,
// with bus-error responses for unmapped addresses and silent slaves, and a fault-capture register.
module dsd9_bus_decoder
    import dsd9_bus_pkg::*;
#(
    parameter int              NS       = 8,
    parameter int              AW       = 32,
    parameter int              DW       = 128,
    parameter logic [NS*AW-1:0] SLV_BASE = '0,
    parameter logic [NS*AW-1:0] SLV_MASK = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m_cyc_i,
    input  logic              m_stb_i,
    input  logic              m_wr_i,
    input  logic [DW/8-1:0]   m_sel_i,
    input  logic [AW-1:0]     m_adr_i,
    input  logic [DW-1:0]     m_dat_i,
    output logic              m_ack_o,
    output logic              m_err_o,
    output logic [DW-1:0]     m_dat_o,
    output logic [NS-1:0]     s_cyc_o,
    output logic [NS-1:0]     s_stb_o,
    input  logic [NS-1:0]     s_ack_i,
    input  logic [NS*DW-1:0]  s_dat_i,
    output logic              s_wr_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic              clr_fault_i,
    output logic              fault_valid_o,
    output logic              fault_cause_o,
    output logic [AW-1:0]     fault_adr_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    bus_state_e     state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [NS-1:0]  strb_q, strb_d;
    logic           s_wr_q, s_wr_d;
    logic [SW-1:0]  s_sel_q, s_sel_d;
    logic [AW-1:0]  s_adr_q, s_adr_d;
    logic [DW-1:0]  s_dat_q, s_dat_d;
    logic [DW-1:0]  m_dat_q, m_dat_d;
    logic           fault_valid_q, fault_valid_d;
    logic           fault_cause_q, fault_cause_d;
    logic [AW-1:0]  fault_adr_q, fault_adr_d;

    logic           hit;
    logic [IW-1:0]  hit_idx;

    dsd9_bus_addr_match #(.NS(NS), .AW(AW), .IW(IW)) u_match (
        .adr_i  (m_adr_i),
        .base_i (SLV_BASE),
        .mask_i (SLV_MASK),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        strb_d        = strb_q;
        s_wr_d        = s_wr_q;
        s_sel_d       = s_sel_q;
        s_adr_d       = s_adr_q;
        s_dat_d       = s_dat_q;
        m_dat_d       = m_dat_q;
        fault_valid_d = clr_fault_i ? 1'b0 : fault_valid_q;
        fault_cause_d = fault_cause_q;
        fault_adr_d   = fault_adr_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (hit) begin
                        idx_d           = hit_idx;
                        s_wr_d          = m_wr_i;
                        s_sel_d         = m_sel_i;
                        s_adr_d         = m_adr_i;
                        s_dat_d         = m_dat_i;
                        strb_d          = '0;
                        strb_d[hit_idx] = 1'b1;
                        timer_d         = '0;
                        state_d         = ST_ACTIVE;
                    end else begin
                        fault_valid_d = 1'b1;
                        fault_cause_d = FC_NODECODE;
                        fault_adr_d   = m_adr_i;
                        state_d       = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                // Abort beats a same-cycle ack; ack beats a same-cycle expiry.
                if (!m_cyc_i) begin
                    strb_d  = '0;
                    state_d = ST_IDLE;
                end else if (s_ack_i[idx_q]) begin
                    if (!s_wr_q) m_dat_d = s_dat_i[int'(idx_q)*DW +: DW];
                    strb_d  = '0;
                    state_d = ST_ACK;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    strb_d        = '0;
                    fault_valid_d = 1'b1;
                    fault_cause_d = FC_TIMEOUT;
                    fault_adr_d   = s_adr_q;
                    state_d       = ST_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ACK, ST_ERR: begin
                if (!m_stb_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            strb_q        <= '0;
            s_wr_q        <= 1'b0;
            s_sel_q       <= '0;
            s_adr_q       <= '0;
            s_dat_q       <= '0;
            m_dat_q       <= '0;
            fault_valid_q <= 1'b0;
            fault_cause_q <= FC_NODECODE;
            fault_adr_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            strb_q        <= strb_d;
            s_wr_q        <= s_wr_d;
            s_sel_q       <= s_sel_d;
            s_adr_q       <= s_adr_d;
            s_dat_q       <= s_dat_d;
            m_dat_q       <= m_dat_d;
            fault_valid_q <= fault_valid_d;
            fault_cause_q <= fault_cause_d;
            fault_adr_q   <= fault_adr_d;
        end
    end

    assign m_ack_o       = (state_q == ST_ACK) && m_stb_i;
    assign m_err_o       = (state_q == ST_ERR) && m_stb_i;
    assign m_dat_o       = m_dat_q;
    assign s_cyc_o       = strb_q;
    assign s_stb_o       = strb_q;
    assign s_wr_o        = s_wr_q;
    assign s_sel_o       = s_sel_q;
    assign s_adr_o       = s_adr_q;
    assign s_dat_o       = s_dat_q;
    assign fault_valid_o = fault_valid_q;
    assign fault_cause_o = fault_cause_q;
    assign fault_adr_o   = fault_adr_q;

endmodule

// File: tb/tb_dsd9_bus_decoder.sv
// Directed bench for dsd9_bus_decoder: table of single transactions plus hand sequences for
// timeout, ack-on-expiry, abort, fault set/clear collision and asynchronous reset.
module tb_dsd9_bus_decoder;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TIMEOUT = 8;
    localparam logic [NS*AW-1:0] BASE = {32'h0000_0000, 32'hFFD0_0000, 32'h0000_0000, 32'hFFFC_0000};
    localparam logic [NS*AW-1:0] MASK = {32'h0000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hFFFC_0000};

    logic              clk = 1'b0;
    logic              rst;
    logic              m_cyc, m_stb, m_wr;
    logic [DW/8-1:0]   m_sel;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_dat;
    logic              m_ack, m_err;
    logic [DW-1:0]     m_dat_o;
    logic [NS-1:0]     s_cyc, s_stb, s_ack;
    logic [NS*DW-1:0]  s_dat;
    logic              s_wr;
    logic [DW/8-1:0]   s_sel;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic              clr_fault;
    logic              f_valid, f_cause;
    logic [AW-1:0]     f_adr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsd9_bus_decoder #(
        .NS(NS), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_wr_i(m_wr), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .s_wr_o(s_wr), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat_o),
        .clr_fault_i(clr_fault),
        .fault_valid_o(f_valid), .fault_cause_o(f_cause), .fault_adr_o(f_adr)
    );

    typedef struct {
        logic [31:0]  adr;
        logic         wr;
        logic [15:0]  sel;
        logic [127:0] wdat;
        logic         hit;
        int           slave;
        int           dly;
        logic [127:0] rdat;
        logic [3:0]   exp_stb;
        logic [127:0] exp_dat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = v.adr; m_wr = v.wr; m_sel = v.sel; m_dat = v.wdat;
        @(negedge clk);
        if (!v.hit) begin
            chk("miss_err", m_err, 1);
            chk("miss_stb", s_stb, 0);
            chk("miss_fvalid", f_valid, 1);
            chk("miss_fcause", f_cause, 0);
            chk("miss_fadr", f_adr, v.adr);
        end else begin
            chk("stb", s_stb, v.exp_stb);
            chk("cyc", s_cyc, v.exp_stb);
            chk("s_adr", s_adr, v.adr);
            chk("s_wr", s_wr, v.wr);
            if (v.wr) begin
                chk("s_sel", s_sel, v.sel);
                chk("s_dat", s_dat_o, v.wdat);
            end
            s_dat[v.slave*DW +: DW] = v.rdat;
            repeat (v.dly) @(negedge clk);
            chk("ack_early", m_ack, 0);
            s_ack[v.slave] = 1'b1;
            @(negedge clk);
            chk("ack", m_ack, 1);
            chk("stb_drop", s_stb, 0);
            s_ack = '0;
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("idle_ack", m_ack, 0);
        chk("idle_err", m_err, 0);
        chk("m_dat", m_dat_o, v.exp_dat);
    endtask

    initial begin
        tbl[0] = '{32'hFFFC_0010, 1'b0, 16'h0000, '0, 1'b1, 0, 1, {32{4'hA}} ^ {16{8'h0F}}, 4'b0001, {32{4'hA}} ^ {16{8'h0F}}};
        tbl[1] = '{32'h0000_1000, 1'b1, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1, 1,
                   {32{4'hD}}, 4'b0010, {32{4'hA}} ^ {16{8'h0F}}};
        tbl[2] = '{32'h8000_0000, 1'b0, 16'h0000, '0, 1'b0, 0, 0, '0, 4'b0000, {32{4'hA}} ^ {16{8'h0F}}};
        tbl[3] = '{32'h0FFF_FFF0, 1'b0, 16'h00FF, '0, 1'b1, 1, 3, {32{4'h5}}, 4'b0010, {32{4'h5}}};
        tbl[4] = '{32'hFFDA_BCD0, 1'b0, 16'hF000, '0, 1'b1, 2, 0, {16{8'hC3}}, 4'b0100, {16{8'hC3}}};
        tbl[5] = '{32'hFFFF_FFF0, 1'b0, 16'h000F, '0, 1'b1, 0, 2, {16{8'h0F}}, 4'b0001, {16{8'h0F}}};

        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_wr = 1'b0; m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = '0; s_dat = '0; clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stb", s_stb, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        chk("rst_fvalid", f_valid, 0);
        chk("rst_mdat", m_dat_o, 0);
        chk("rst_sadr", s_adr, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Silent slave 2: error TIMEOUT+1 cycles after the strobe appears.
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_wr = 1'b0; m_adr = 32'hFFD0_0010;
        @(negedge clk);
        chk("to_stb", s_stb, 4'b0100);
        repeat (8) @(negedge clk);
        chk("to_err_early", m_err, 0);
        chk("to_stb_held", s_stb, 4'b0100);
        @(negedge clk);
        chk("to_err", m_err, 1);
        chk("to_stb_drop", s_stb, 0);
        chk("to_fvalid", f_valid, 1);
        chk("to_fcause", f_cause, 1);
        chk("to_fadr", f_adr, 32'hFFD0_0010);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        chk("clr_fvalid", f_valid, 0);

        // Slave 3 acks spuriously throughout; slave 1 acks on the expiry cycle.
        s_dat[3*DW +: DW] = {32{4'h3}};
        s_dat[1*DW +: DW] = {32{4'h7}};
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_2000;
        @(negedge clk);
        chk("sp_stb", s_stb, 4'b0010);
        s_ack = 4'b1000;
        repeat (8) @(negedge clk);
        chk("sp_ack_early", m_ack, 0);
        chk("sp_err_early", m_err, 0);
        s_ack = 4'b1010;
        @(negedge clk);
        chk("exp_ack", m_ack, 1);
        chk("exp_err", m_err, 0);
        chk("exp_mdat", m_dat_o, {32{4'h7}});
        chk("exp_fvalid", f_valid, 0);
        s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);

        // Abort: master drops cyc while the slave is strobed.
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'hFFFC_0020;
        @(negedge clk);
        chk("ab_stb", s_stb, 4'b0001);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("ab_stb_drop", s_stb, 0);
        chk("ab_ack", m_ack, 0);
        chk("ab_err", m_err, 0);
        chk("ab_mdat", m_dat_o, {32{4'h7}});

        // Fault set and clear on the same edge: set wins.
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h9000_0000; clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        chk("sc_fvalid", f_valid, 1);
        chk("sc_fadr", f_adr, 32'h9000_0000);
        chk("sc_err", m_err, 1);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an access.
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'hFFFC_0030;
        @(negedge clk);
        chk("mr_stb", s_stb, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("mr_stb_rst", s_stb, 0);
        chk("mr_cyc_rst", s_cyc, 0);
        chk("mr_sadr", s_adr, 0);
        chk("mr_mdat", m_dat_o, 0);
        chk("mr_fvalid", f_valid, 0);
        chk("mr_fadr", f_adr, 0);
        chk("mr_ack", m_ack, 0);
        chk("mr_err", m_err, 0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
